// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
      VERIFY_REQ,
      VERIFY_WAIT,
      DONE
   } state_t;

   localparam int         BYTES_PER_WORD = 4;
   localparam logic [3:0] BYTEEN_ALL     = 4'hF;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs accepted stream bytes little-endian into a 32-bit word.
// word_valid marks the cycle whose clock edge stores the final byte.
module imem_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_ready,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam int LANE_W = $clog2(BYTES_PER_WORD);

   logic [LANE_W-1:0] lane_reg;
   logic              accept;

   assign accept     = s_valid && s_ready;
   assign word_valid = accept && (lane_reg == LANE_W'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lane_reg <= '0;
      end else if (clear) begin
         lane_reg <= '0;
      end else if (accept) begin
         lane_reg <= lane_reg + 1'b1;
      end
   end

   // One register per byte lane; the lane counter selects which one loads.
   generate
      for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         logic [7:0] lane_byte_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               lane_byte_reg <= '0;
            end else if (clear) begin
               lane_byte_reg <= '0;
            end else if (accept && (lane_reg == LANE_W'(gi))) begin
               lane_byte_reg <= s_data;
            end
         end

         assign word[8*gi +: 8] = lane_byte_reg;
      end
   endgenerate

endmodule

// File: rtl/imem_stream_loader.sv
// Avalon-MM master: loads a byte stream into instruction memory as words,
// then reads the block back and compares checksums.
module imem_stream_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W       = 14,
   parameter int CNT_W        = 15,
   parameter int READ_LATENCY = 1
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_words,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic              avm_read,
   output logic [3:0]        avm_byteenable,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_waitrequest,
   output logic              busy,
   output logic              done,
   output logic [31:0]       checksum,
   output logic              verify_error
);

   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   logic [CNT_W-1:0]  num_reg, num_next;
   logic [CNT_W-1:0]  idx_reg, idx_next;
   logic [31:0]       checksum_reg, checksum_next;
   logic [31:0]       rsum_reg, rsum_next;
   logic              verify_error_reg, verify_error_next;
   logic [LAT_W-1:0]  lat_reg, lat_next;

   logic              pack_clear;
   logic [31:0]       word;
   logic              word_valid;
   logic [CNT_W-1:0]  idx_inc;
   logic              last_word;

   assign idx_inc   = idx_reg + CNT_W'(1);
   assign last_word = (idx_inc == num_reg);

   imem_byte_packer u_packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (pack_clear),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= IDLE;
         base_reg         <= '0;
         num_reg          <= '0;
         idx_reg          <= '0;
         checksum_reg     <= '0;
         rsum_reg         <= '0;
         verify_error_reg <= 1'b0;
         lat_reg          <= '0;
      end else begin
         state_reg        <= state_next;
         base_reg         <= base_next;
         num_reg          <= num_next;
         idx_reg          <= idx_next;
         checksum_reg     <= checksum_next;
         rsum_reg         <= rsum_next;
         verify_error_reg <= verify_error_next;
         lat_reg          <= lat_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      base_next         = base_reg;
      num_next          = num_reg;
      idx_next          = idx_reg;
      checksum_next     = checksum_reg;
      rsum_next         = rsum_reg;
      verify_error_next = verify_error_reg;
      lat_next          = lat_reg;
      pack_clear        = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               base_next         = base_addr;
               num_next          = num_words;
               idx_next          = '0;
               checksum_next     = '0;
               rsum_next         = '0;
               verify_error_next = 1'b0;
               pack_clear        = 1'b1;
               state_next        = (num_words == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (word_valid) state_next = WRITE;
         end
         WRITE: begin
            if (!avm_waitrequest) begin
               checksum_next = checksum_reg + word;
               if (last_word) begin
                  idx_next   = '0;
                  state_next = VERIFY_REQ;
               end else begin
                  idx_next   = idx_inc;
                  state_next = COLLECT;
               end
            end
         end
         VERIFY_REQ: begin
            if (!avm_waitrequest) begin
               lat_next   = LAT_W'(READ_LATENCY - 1);
               state_next = VERIFY_WAIT;
            end
         end
         VERIFY_WAIT: begin
            // Readdata is valid READ_LATENCY edges after the accept edge.
            if (lat_reg == '0) begin
               rsum_next  = rsum_reg + avm_readdata;
               idx_next   = idx_inc;
               state_next = last_word ? DONE : VERIFY_REQ;
            end else begin
               lat_next = lat_reg - 1'b1;
            end
         end
         DONE: begin
            verify_error_next = (rsum_reg != checksum_reg);
            state_next        = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign s_ready        = (state_reg == COLLECT);
   assign avm_write      = (state_reg == WRITE);
   assign avm_read       = (state_reg == VERIFY_REQ);
   assign avm_chipselect = avm_write || avm_read;
   assign avm_byteenable = avm_chipselect ? BYTEEN_ALL : 4'h0;
   assign avm_address    = avm_chipselect ? (base_reg + idx_reg[ADDR_W-1:0]) : '0;
   assign avm_writedata  = avm_write ? word : '0;
   assign busy           = (state_reg != IDLE);
   assign done           = (state_reg == DONE);
   assign checksum       = checksum_reg;
   // The comparison is presented combinationally so it is already valid during done.
   assign verify_error   = (state_reg == DONE) ? (rsum_reg != checksum_reg) : verify_error_reg;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed self-checking bench for imem_stream_loader with an on-chip memory model.
module tb_imem_stream_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [13:0] base_addr;
   logic [14:0] num_words;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [13:0] avm_address;
   logic        avm_chipselect;
   logic        avm_write;
   logic        avm_read;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        busy;
   logic        done;
   logic [31:0] checksum;
   logic        verify_error;

   int checks = 0;
   int errors = 0;

   imem_stream_loader dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .base_addr       (base_addr),
      .num_words       (num_words),
      .s_data          (s_data),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .avm_address     (avm_address),
      .avm_chipselect  (avm_chipselect),
      .avm_write       (avm_write),
      .avm_read        (avm_read),
      .avm_byteenable  (avm_byteenable),
      .avm_writedata   (avm_writedata),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .busy            (busy),
      .done            (done),
      .checksum        (checksum),
      .verify_error    (verify_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Memory model: read latency 1, optional stall of 3 cycles per request, optional corruption.
   logic [31:0] mem [0:16383];
   logic        stall_en   = 1'b0;
   logic        corrupt_en = 1'b0;
   int          stall_cnt  = 0;

   assign avm_waitrequest = stall_en && avm_chipselect && (stall_cnt < 3);

   always @(posedge clk) begin
      if (!avm_chipselect || !avm_waitrequest) stall_cnt <= 0;
      else                                     stall_cnt <= stall_cnt + 1;
      if (avm_chipselect && avm_write && !avm_waitrequest)
         mem[avm_address] <= avm_writedata;
      if (avm_chipselect && avm_read && !avm_waitrequest)
         avm_readdata <= mem[avm_address] ^ ((corrupt_en && avm_address == 14'h0011) ? 32'h1 : 32'h0);
   end

   // Bus monitor, sampled on the falling edge.
   logic [13:0] wr_addr_q [$];
   logic [31:0] wr_data_q [$];
   int          rd_count = 0;
   int          done_cnt = 0;
   logic [31:0] done_sum = '0;
   logic        done_verr = 1'b0;
   logic        prev_stall = 1'b0;
   logic [13:0] prev_addr = '0;
   logic [31:0] prev_data = '0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (avm_chipselect) check("rw_exclusive", {31'd0, avm_read && avm_write}, 32'd0);
         if (prev_stall && avm_chipselect) begin
            check("stall_addr", {18'd0, avm_address}, {18'd0, prev_addr});
            check("stall_data", avm_writedata, prev_data);
         end
         if (avm_chipselect && avm_write && !avm_waitrequest) begin
            wr_addr_q.push_back(avm_address);
            wr_data_q.push_back(avm_writedata);
            $display("WR  addr=%h data=%h", avm_address, avm_writedata);
         end
         if (avm_chipselect && avm_read && !avm_waitrequest) begin
            rd_count <= rd_count + 1;
            $display("RD  addr=%h", avm_address);
         end
         if (done) begin
            done_cnt  <= done_cnt + 1;
            done_sum  <= checksum;
            done_verr <= verify_error;
            $display("DONE checksum=%h verify_error=%b", checksum, verify_error);
         end
         prev_stall <= avm_chipselect && avm_waitrequest;
         prev_addr  <= avm_address;
         prev_data  <= avm_writedata;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   logic [7:0]  stim     [0:15];
   logic [13:0] exp_addr [0:3];
   logic [31:0] exp_data [0:3];
   int          rd_base;
   int          done_base;

   task automatic start_load(input logic [13:0] base, input logic [14:0] n);
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_base   = rd_count;
      done_base = done_cnt;
      @(negedge clk);
      start = 1'b1; base_addr = base; num_words = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic feed(input int nbytes, input int gap);
      int t;
      for (int i = 0; i < nbytes; i++) begin
         if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         s_valid = 1'b1;
         s_data  = stim[i];
         t = 0;
         while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (t >= 100) check("byte_accept_timeout", 32'd0, 32'd1);
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic finish_and_check(input int n, input logic [31:0] exp_sum, input logic exp_verr);
      int t = 0;
      while (done_cnt == done_base && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) check("done_timeout", 32'd0, 32'd1);
      repeat (3) @(negedge clk);
      check("wr_count", wr_addr_q.size(), n);
      for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
         check("wr_addr", {18'd0, wr_addr_q[i]}, {18'd0, exp_addr[i]});
         check("wr_data", wr_data_q[i], exp_data[i]);
      end
      check("rd_count", rd_count - rd_base, n);
      check("done_pulses", done_cnt - done_base, 1);
      check("done_checksum", done_sum, exp_sum);
      check("done_verify_error", {31'd0, done_verr}, {31'd0, exp_verr});
      check("held_checksum", checksum, exp_sum);
      check("held_verify_error", {31'd0, verify_error}, {31'd0, exp_verr});
      check("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic set_basic_expect();
      for (int i = 0; i < 12; i++) stim[i] = 8'(i + 1);
      exp_addr[0] = 14'h0010; exp_data[0] = 32'h04030201;
      exp_addr[1] = 14'h0011; exp_data[1] = 32'h08070605;
      exp_addr[2] = 14'h0012; exp_data[2] = 32'h0C0B0A09;
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
      s_data = '0; s_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_s_ready", {31'd0, s_ready}, 32'd0);
      check("rst_chipselect", {31'd0, avm_chipselect}, 32'd0);
      check("rst_checksum", checksum, 32'd0);
      check("rst_verify_error", {31'd0, verify_error}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic three-word load
      set_basic_expect();
      start_load(14'h0010, 15'd3);
      feed(12, 0);
      finish_and_check(3, 32'h1815120F, 1'b0);

      // Same load with slave stalls and gapped stream
      stall_en = 1'b1;
      start_load(14'h0010, 15'd3);
      feed(12, 2);
      finish_and_check(3, 32'h1815120F, 1'b0);
      stall_en = 1'b0;

      // Address wrap at top of memory
      for (int i = 0; i < 8; i++) stim[i] = 8'(8'hA1 + i);
      exp_addr[0] = 14'h3FFF; exp_data[0] = 32'hA4A3A2A1;
      exp_addr[1] = 14'h0000; exp_data[1] = 32'hA8A7A6A5;
      start_load(14'h3FFF, 15'd2);
      feed(8, 0);
      finish_and_check(2, 32'h4D4B4946, 1'b0);

      // Zero-word load: done in the cycle right after the start cycle, no bus traffic
      wr_addr_q.delete();
      rd_base   = rd_count;
      done_base = done_cnt;
      @(negedge clk);
      start = 1'b1; base_addr = 14'h0123; num_words = 15'd0;
      @(negedge clk);
      start = 1'b0;
      check("zero_done_next_cycle", {31'd0, done}, 32'd1);
      check("zero_checksum", checksum, 32'd0);
      check("zero_verify_error", {31'd0, verify_error}, 32'd0);
      repeat (3) @(negedge clk);
      check("zero_done_low", {31'd0, done}, 32'd0);
      check("zero_wr_count", wr_addr_q.size(), 0);
      check("zero_rd_count", rd_count - rd_base, 0);

      // Read-back corruption at 0x0011
      set_basic_expect();
      corrupt_en = 1'b1;
      start_load(14'h0010, 15'd3);
      feed(12, 0);
      finish_and_check(3, 32'h1815120F, 1'b1);
      corrupt_en = 1'b0;

      // Reset during the second write
      start_load(14'h0010, 15'd3);
      feed(8, 0);
      check("pre_reset_write", {31'd0, avm_write}, 32'd1);
      check("pre_reset_addr", {18'd0, avm_address}, 32'h0011);
      reset_n = 1'b0;
      #1;
      check("mid_rst_write", {31'd0, avm_write}, 32'd0);
      check("mid_rst_chipselect", {31'd0, avm_chipselect}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_checksum", checksum, 32'd0);
      check("mid_rst_address", {18'd0, avm_address}, 32'd0);
      check("mid_rst_writedata", avm_writedata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_wr_count", wr_addr_q.size(), 1);
      check("mid_rst_no_done", done_cnt - done_base, 0);

      // Clean restart from base after the abandoned load
      set_basic_expect();
      start_load(14'h0010, 15'd3);
      feed(12, 0);
      finish_and_check(3, 32'h1815120F, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
